// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-compare helpers for sync_fifo_param.
// Wrap-bit pointers: equal means empty, MSB-only difference means full.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 16;

  function automatic logic ptr_empty(
    input logic [31:0] wp,
    input logic [31:0] rp
  );
    return wp == rp;
  endfunction

  function automatic logic ptr_full(
    input logic [31:0] wp,
    input logic [31:0] rp,
    input int          aw
  );
    return (wp ^ rp) == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// WIDTH x DEPTH storage: synchronous write port, asynchronous read port.
module sync_fifo_ram #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] AF_C = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C = AE_THRESH[ADDR_W:0];

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = wr_en & (~full_q | rd_acc);

  sync_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags track next-state so they move in step with count.
    full_d  = ptr_full(32'(wr_ptr_d), 32'(rd_ptr_d), ADDR_W);
    empty_d = ptr_empty(32'(wr_ptr_d), 32'(rd_ptr_d));
    af_d    = count_d >= AF_C;
    ae_d    = count_d <= AE_C;
    ovf_d   = (ovf_q & ~err_clr) | (wr_en & ~wr_acc);
    udf_d   = (udf_q & ~err_clr) | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout       = ram_rdata;
  assign dout_valid = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;

  always_comb begin
    dout_d = dout_q;
    dv_d   = rd_acc;
    if (rd_acc) dout_d = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at WIDTH=8, DEPTH=16.
// Standard mode by default; FWFT sequence when SYNC_FIFO_FWFT_EN is set.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int passed = 0;
  int total  = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_dv", 32'(dout_valid), 0);
`ifdef SYNC_FIFO_FWFT_EN
    wr_en = 1'b1; din = 8'hA5;
    step();
    wr_en = 1'b0;
    step();
    chk("fwft_dout", 32'(dout), 32'hA5);
    chk("fwft_dv", 32'(dout_valid), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_empty", 32'(empty), 1);
    chk("fwft_dv0", 32'(dout_valid), 0);
    chk("fwft_count", 32'(count), 0);
`else
    chk("rst_dout", 32'(dout), 0);
    // Fill with 0x01..0x10
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      din = 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 14));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
      chk("fill_full", 32'(full), 32'(i == 16));
    end
    din = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    // Drain
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("drain_dout", 32'(dout), 32'(i));
      chk("drain_dv", 32'(dout_valid), 1);
      chk("drain_count", 32'(count), 32'(16 - i));
      chk("drain_empty", 32'(empty), 32'(i == 16));
    end
    step();
    rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dout", 32'(dout), 32'h10);
    chk("udf_dv", 32'(dout_valid), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    // Wrap: two write/read bursts of 10 across the pointer wrap
    for (int b = 0; b < 2; b++) begin
      wr_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
        din = 8'(8'h20 + b * 16 + k);
        q.push_back(din);
        step();
        chk("wrap_wcount", 32'(count), 32'(q.size()));
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
        exp_d = q.pop_front();
        step();
        chk("wrap_dout", 32'(dout), 32'(exp_d));
        chk("wrap_rcount", 32'(count), 32'(q.size()));
      end
      rd_en = 1'b0;
    end
    // Simultaneous read/write at full
    wr_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = 8'(8'h40 + k);
      q.push_back(din);
      step();
    end
    chk("sim_full", 32'(full), 1);
    rd_en = 1'b1; din = 8'h99;
    q.push_back(din);
    exp_d = q.pop_front();
    step();
    wr_en = 1'b0;
    chk("simf_count", 32'(count), 16);
    chk("simf_ovf", 32'(overflow), 0);
    chk("simf_dout", 32'(dout), 32'(exp_d));
    for (int k = 0; k < 16; k++) begin
      exp_d = q.pop_front();
      step();
      chk("simf_drain", 32'(dout), 32'(exp_d));
    end
    chk("simf_empty", 32'(empty), 1);
    // Simultaneous read/write at empty
    wr_en = 1'b1; din = 8'h77;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sime_count", 32'(count), 1);
    chk("sime_udf", 32'(underflow), 1);
    chk("sime_dv", 32'(dout_valid), 0);
    // Reach count 7 with overflow set, then reset
    wr_en = 1'b1; din = 8'h55;
    for (int k = 0; k < 16; k++) step();
    wr_en = 1'b0;
    chk("pre_ovf", 32'(overflow), 1);
    rd_en = 1'b1;
    for (int k = 0; k < 9; k++) step();
    rd_en = 1'b0;
    chk("pre_count", 32'(count), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_dout", 32'(dout), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ec_udf", 32'(underflow), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ec_clr", 32'(underflow), 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
